// File: rtl/status_flag_stack.sv
// ============================================================================
// status_flag_stack : condition-code register with masked updates, LIFO
// save/restore stack, branch bit select and sticky stack-error flags. Rev 1.0
// ============================================================================
`default_nettype none

module status_flag_stack #(
  parameter int                FLAG_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [FLAG_W-1:0] RESET_VAL   = {1'b1, {(FLAG_W-1){1'b0}}},
  parameter int                SEL_W       = 2,
  parameter int                CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              update_en_i,
  input  logic [1:0]        op_i,
  input  logic [FLAG_W-1:0] flag_mask_i,
  input  logic [FLAG_W-1:0] new_flags_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [SEL_W-1:0]  bit_sel_i,
  input  logic              err_clear_i,
  output logic [FLAG_W-1:0] flags_o,
  output logic              cond_bit_o,
  output logic [CNT_W-1:0]  depth_o,
  output logic              stack_full_o,
  output logic              stack_empty_o,
  output logic              err_overflow_o,
  output logic              err_underflow_o
);

  localparam int         IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_W-1:0] stack_d [STACK_DEPTH];
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic [FLAG_W-1:0] w_op_flags;
  logic [FLAG_W-1:0] w_upd_flags;

  always_comb begin
    w_full     = (depth_q == CNT_W'(STACK_DEPTH));
    w_empty    = (depth_q == '0);
    w_push_idx = IDX_W'(depth_q);
    w_top_idx  = IDX_W'(depth_q - CNT_W'(1));
    w_op_flags = flags_q;
    case (op_i)
      OP_LOAD:   w_op_flags = (flags_q & ~flag_mask_i) | (new_flags_i & flag_mask_i);
      OP_CLEAR:  w_op_flags = flags_q & ~flag_mask_i;
      OP_SET:    w_op_flags = flags_q | flag_mask_i;
      OP_TOGGLE: w_op_flags = flags_q ^ flag_mask_i;
      default:   w_op_flags = flags_q;
    endcase
    w_upd_flags = update_en_i ? w_op_flags : flags_q;
  end

  always_comb begin
    flags_d   = flags_q;
    stack_d   = stack_q;
    depth_d   = depth_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    if (!stall_i) begin
      // Clear first so a same-cycle error below overrides it.
      if (err_clear_i) begin
        err_ovf_d = 1'b0;
        err_unf_d = 1'b0;
      end
      flags_d = w_upd_flags;
      if (push_i && pop_i && !w_empty) begin
        flags_d            = stack_q[w_top_idx];
        stack_d[w_top_idx] = flags_q;
      end else if (pop_i && !w_empty) begin
        flags_d = stack_q[w_top_idx];
        depth_d = depth_q - CNT_W'(1);
      end else begin
        if (pop_i) begin
          err_unf_d = 1'b1;
        end
        if (push_i) begin
          if (w_full) begin
            err_ovf_d = 1'b1;
          end else begin
            stack_d[w_push_idx] = flags_q;
            depth_d             = depth_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= RESET_VAL;
      stack_q   <= '{default: '0};
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      stack_q   <= stack_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign flags_o         = flags_q;
  assign cond_bit_o      = (32'(bit_sel_i) >= FLAG_W) ? flags_q[FLAG_W-1] : flags_q[bit_sel_i];
  assign depth_o         = depth_q;
  assign stack_full_o    = w_full;
  assign stack_empty_o   = w_empty;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;

endmodule

`default_nettype wire
